// File: rtl/input_width_transform_if.sv
// ----------------------------------------------------------------------------
// input_width_transform_if
// Word bus between the receive byte packer and the downstream 134-bit
// receive FIFO.
//   ov_data        134  packet word: [133:132] position, [131:128] invalid
//                       bytes, [127:0] data with the first byte at [127:120]
//   o_data_wr        1  ov_data valid, one cycle per word
//   iv_fifo_usedw    7  FIFO fill level in words, returned by the FIFO
// Modports:
//   master  packer side (drives the word, reads the fill level)
//   slave   FIFO side   (takes the word, reports the fill level)
// ----------------------------------------------------------------------------
interface input_width_transform_if;
  logic [133:0] ov_data;
  logic         o_data_wr;
  logic [6:0]   iv_fifo_usedw;

  modport master (
    output ov_data,
    output o_data_wr,
    input  iv_fifo_usedw
  );

  modport slave (
    input  ov_data,
    input  o_data_wr,
    output iv_fifo_usedw
  );
endinterface

// File: rtl/input_width_transform.sv
// ----------------------------------------------------------------------------
// input_width_transform
// Packs an 8-bit GMII receive byte stream into 134-bit packet words with a
// 2-bit position header (01 head, 00 middle, 10 tail, 11 head+tail) and a
// 4-bit invalid-byte count. Frames are dropped whole when the downstream FIFO
// is too full at their first byte, and truncated beyond MAX_BYTES.
//
// Ports:
//   i_clk                 core clock
//   i_rst                 synchronous active-high reset
//   iv_data               receive byte
//   i_data_wr             byte valid, high for the whole frame
//   iv_syned_global_time  synchronized global time
//   rx_bus (master)       ov_data / o_data_wr out, iv_fifo_usedw in
//   ov_rx_timestamp       arrival time of the current frame
//   o_pkt_drop_pulse      one pulse per frame dropped for lack of FIFO space
//   o_oversize_pulse      one pulse per truncated frame
//
// Optional feature macro: IWT_RX_TIMESTAMP_EN
//   defined     -> arrival time captured at the first byte of an accepted
//                  frame, presented with that frame's head word
//   not defined -> ov_rx_timestamp is constant 0, no timestamp register
// ----------------------------------------------------------------------------
module input_width_transform #(
  parameter int MAX_BYTES   = 1536,
  parameter int DROP_THRESH = 32
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [7:0]                    iv_data,
  input  logic                          i_data_wr,
  input  logic [47:0]                   iv_syned_global_time,
  input_width_transform_if.master       rx_bus,
  output logic [47:0]                   ov_rx_timestamp,
  output logic                          o_pkt_drop_pulse,
  output logic                          o_oversize_pulse
);

  localparam logic [10:0] MAX_LIM  = 11'(MAX_BYTES);
  localparam logic [6:0]  DROP_LIM = 7'(DROP_THRESH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DISC = 2'd2
  } state_t;

  state_t      state;
  logic [10:0] byte_cnt;
  logic [4:0]  lane_cnt;
  logic        head_pend;
  logic        prev_wr;
  logic [7:0]  lanes [16];
  logic [127:0] packed_word;
  logic [4:0]  tail_gap;
  logic [3:0]  tail_inv;

  // Lane 0 is the first byte on the wire and sits at the top of the word.
  always_comb begin
    packed_word = '0;
    for (int i = 0; i < 16; i++) begin
      packed_word[8*(15-i) +: 8] = lanes[i];
    end
    tail_gap = 5'd16 - lane_cnt;
    tail_inv = tail_gap[3:0];
  end

`ifdef IWT_RX_TIMESTAMP_EN
  logic [47:0] ts_sample;
`else
  logic unused_time;
  assign unused_time     = ^iv_syned_global_time;
  assign ov_rx_timestamp = '0;
`endif

  // prev_wr is forced high in reset so a frame still running when reset
  // releases is not mistaken for a new frame start and gets discarded.
  // A full word is held back until the next byte or end-of-frame, so the
  // tail of a 16-byte-multiple frame carries invalid count 0.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state            <= IDLE;
      byte_cnt         <= '0;
      lane_cnt         <= '0;
      head_pend        <= 1'b0;
      prev_wr          <= 1'b1;
      for (int i = 0; i < 16; i++) lanes[i] <= '0;
      rx_bus.ov_data   <= '0;
      rx_bus.o_data_wr <= 1'b0;
      o_pkt_drop_pulse <= 1'b0;
      o_oversize_pulse <= 1'b0;
`ifdef IWT_RX_TIMESTAMP_EN
      ts_sample        <= '0;
      ov_rx_timestamp  <= '0;
`endif
    end else begin
      prev_wr          <= i_data_wr;
      rx_bus.o_data_wr <= 1'b0;
      o_pkt_drop_pulse <= 1'b0;
      o_oversize_pulse <= 1'b0;

      case (state)
        IDLE: begin
          if (i_data_wr) begin
            if (prev_wr) begin
              state <= DISC;
            end else if (rx_bus.iv_fifo_usedw > DROP_LIM) begin
              o_pkt_drop_pulse <= 1'b1;
              state            <= DISC;
            end else begin
              for (int i = 1; i < 16; i++) lanes[i] <= '0;
              lanes[0]  <= iv_data;
              byte_cnt  <= 11'd1;
              lane_cnt  <= 5'd1;
              head_pend <= 1'b1;
              state     <= RECV;
`ifdef IWT_RX_TIMESTAMP_EN
              ts_sample <= iv_syned_global_time;
`endif
            end
          end
        end

        RECV: begin
          if (i_data_wr) begin
            if (byte_cnt == MAX_LIM) begin
              rx_bus.ov_data   <= {head_pend ? 2'b11 : 2'b10, tail_inv, packed_word};
              rx_bus.o_data_wr <= 1'b1;
              o_oversize_pulse <= 1'b1;
              head_pend        <= 1'b0;
              state            <= DISC;
`ifdef IWT_RX_TIMESTAMP_EN
              if (head_pend) ov_rx_timestamp <= ts_sample;
`endif
            end else if (lane_cnt == 5'd16) begin
              rx_bus.ov_data   <= {head_pend ? 2'b01 : 2'b00, 4'd0, packed_word};
              rx_bus.o_data_wr <= 1'b1;
              head_pend        <= 1'b0;
              for (int i = 1; i < 16; i++) lanes[i] <= '0;
              lanes[0]         <= iv_data;
              lane_cnt         <= 5'd1;
              byte_cnt         <= byte_cnt + 11'd1;
`ifdef IWT_RX_TIMESTAMP_EN
              if (head_pend) ov_rx_timestamp <= ts_sample;
`endif
            end else begin
              lanes[lane_cnt[3:0]] <= iv_data;
              lane_cnt             <= lane_cnt + 5'd1;
              byte_cnt             <= byte_cnt + 11'd1;
            end
          end else begin
            rx_bus.ov_data   <= {head_pend ? 2'b11 : 2'b10, tail_inv, packed_word};
            rx_bus.o_data_wr <= 1'b1;
            head_pend        <= 1'b0;
            state            <= IDLE;
`ifdef IWT_RX_TIMESTAMP_EN
            if (head_pend) ov_rx_timestamp <= ts_sample;
`endif
          end
        end

        DISC: begin
          if (!i_data_wr) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_input_width_transform.sv
// ----------------------------------------------------------------------------
// tb_input_width_transform
// Directed frames into input_width_transform; every written word is captured
// and compared with values built from the frame length and byte pattern.
// ----------------------------------------------------------------------------
module tb_input_width_transform;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  data = '0;
  logic        wr = 1'b0;
  logic [47:0] gtime = '0;
  logic [47:0] ts;
  logic        drop_p;
  logic        over_p;

  int check_cnt = 0;
  int err_cnt   = 0;

  input_width_transform_if bus();

  input_width_transform dut (
    .i_clk                (clk),
    .i_rst                (rst),
    .iv_data              (data),
    .i_data_wr            (wr),
    .iv_syned_global_time (gtime),
    .rx_bus               (bus),
    .ov_rx_timestamp      (ts),
    .o_pkt_drop_pulse     (drop_p),
    .o_oversize_pulse     (over_p)
  );

  always #5 clk = ~clk;

  // Capture every word and pulse away from the active edge.
  logic [133:0] words [$];
  int           drop_cnt = 0;
  int           over_cnt = 0;
  logic [47:0]  head_ts  = '0;

  always @(negedge clk) begin
    if (bus.o_data_wr) begin
      words.push_back(bus.ov_data);
      if (bus.ov_data[132]) head_ts = ts;
    end
    if (drop_p) drop_cnt++;
    if (over_p) over_cnt++;
  end

  task automatic checkOutput(input string tag, input logic [133:0] actual,
                             input logic [133:0] expected);
    check_cnt++;
    if (actual !== expected) begin
      err_cnt++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Expected word k of a frame of len bytes whose byte i is (base + i).
  function automatic logic [133:0] expWord(input int len, input int base, input int k);
    int eff, nw, nb;
    logic [127:0] d;
    logic [1:0]   h;
    logic [3:0]   inv;
    eff = (len > 1536) ? 1536 : len;
    nw  = (eff + 15) / 16;
    nb  = (k == nw - 1) ? eff - 16 * k : 16;
    d   = '0;
    for (int j = 0; j < nb; j++) d[8*(15-j) +: 8] = 8'(base + 16 * k + j);
    h   = {(k == nw - 1), (k == 0)};
    inv = (k == nw - 1) ? 4'(16 - nb) : 4'd0;
    return {h, inv, d};
  endfunction

  function automatic int wordsFor(input int len);
    int eff;
    eff = (len > 1536) ? 1536 : len;
    return (eff + 15) / 16;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int len, input int base,
                               input logic [6:0] usedw, input int gap);
    bus.iv_fifo_usedw = usedw;
    for (int i = 0; i < len; i++) begin
      @(posedge clk);
      #1;
      data  = 8'(base + i);
      wr    = 1'b1;
      gtime = (i == 0) ? 48'h1234 : 48'h9999;
    end
    for (int g = 0; g < gap; g++) begin
      @(posedge clk);
      #1;
      wr   = 1'b0;
      data = '0;
    end
  endtask

  task automatic checkFrame(input string tag, input int len, input int base,
                            input int start);
    for (int k = 0; k < wordsFor(len); k++) begin
      if (start + k < words.size())
        checkOutput($sformatf("%s w%0d", tag, k), words[start + k], expWord(len, base, k));
    end
  endtask

  int s, s2, d0, o0;

  initial begin
    bus.iv_fifo_usedw = '0;
    idle(3);
    checkOutput("rst ov_data", bus.ov_data, '0);
    checkOutput("rst o_data_wr", 134'(bus.o_data_wr), '0);
    checkOutput("rst timestamp", 134'(ts), '0);
    checkOutput("rst drop", 134'(drop_p), '0);
    checkOutput("rst oversize", 134'(over_p), '0);
    rst = 1'b0;
    idle(2);

    // 65 bytes 0x00..0x40
    s = words.size();
    applyStimulus(65, 0, 7'd0, 1);
    idle(4);
    checkOutput("65B count", 134'(words.size() - s), 134'(5));
    if (words.size() - s == 5) begin
      checkOutput("65B head hdr", 134'(words[s][133:132]), 134'(2'b01));
      checkOutput("65B first byte", 134'(words[s][127:120]), 134'(8'h00));
      checkOutput("65B mid hdr", 134'(words[s+2][133:132]), 134'(2'b00));
      checkOutput("65B tail hdr", 134'(words[s+4][133:132]), 134'(2'b10));
      checkOutput("65B tail inv", 134'(words[s+4][131:128]), 134'(4'd15));
      checkOutput("65B tail byte", 134'(words[s+4][127:120]), 134'(8'h40));
      checkOutput("65B tail rest", 134'(words[s+4][119:0]), '0);
    end
    checkFrame("65B", 65, 0, s);

    // single byte
    s = words.size();
    applyStimulus(1, 8'hAA, 7'd0, 1);
    idle(4);
    checkOutput("1B count", 134'(words.size() - s), 134'(1));
    if (words.size() > s)
      checkOutput("1B word", words[s], {2'b11, 4'd15, 8'hAA, 120'd0});

    // exact multiples of 16
    s = words.size();
    applyStimulus(16, 8'h10, 7'd0, 1);
    idle(4);
    checkOutput("16B count", 134'(words.size() - s), 134'(1));
    if (words.size() > s)
      checkOutput("16B hdr+inv", 134'(words[s][133:128]), 134'({2'b11, 4'd0}));
    checkFrame("16B", 16, 8'h10, s);
    s = words.size();
    applyStimulus(32, 8'h80, 7'd0, 1);
    idle(4);
    checkOutput("32B count", 134'(words.size() - s), 134'(2));
    checkFrame("32B", 32, 8'h80, s);

    // drop on full FIFO, then exactly at threshold
    s = words.size();
    d0 = drop_cnt;
    applyStimulus(64, 8'h20, 7'd33, 1);
    idle(4);
    checkOutput("drop count", 134'(words.size() - s), '0);
    checkOutput("drop pulse", 134'(drop_cnt - d0), 134'(1));
    s = words.size();
    applyStimulus(64, 8'h30, 7'd32, 1);
    idle(4);
    checkOutput("thresh count", 134'(words.size() - s), 134'(4));
    checkFrame("thresh", 64, 8'h30, s);
    checkOutput("thresh no drop", 134'(drop_cnt - d0), 134'(1));

    // oversize then back-to-back 64-byte frame with one idle cycle
    s = words.size();
    d0 = drop_cnt;
    o0 = over_cnt;
    applyStimulus(1600, 3, 7'd0, 1);
    applyStimulus(64, 8'h55, 7'd0, 1);
    idle(4);
    checkOutput("over count", 134'(words.size() - s), 134'(100));
    if (words.size() - s == 100)
      checkOutput("over last", 134'(words[s+95][133:128]), 134'({2'b10, 4'd0}));
    checkFrame("over", 1600, 3, s);
    checkFrame("after over", 64, 8'h55, s + 96);
    checkOutput("over pulse", 134'(over_cnt - o0), 134'(1));
    checkOutput("over no drop", 134'(drop_cnt - d0), '0);

    // two short frames with a single idle cycle
    s = words.size();
    applyStimulus(20, 8'hC0, 7'd0, 1);
    applyStimulus(17, 8'hE0, 7'd0, 1);
    idle(4);
    checkOutput("b2b count", 134'(words.size() - s), 134'(4));
    checkFrame("b2b A", 20, 8'hC0, s);
    checkFrame("b2b B", 17, 8'hE0, s + 2);

    // reset in the middle of a frame; remainder must be discarded
    bus.iv_fifo_usedw = '0;
    s2 = words.size();
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (i == 21) begin
        checkOutput("midrst ov_data", bus.ov_data, '0);
        checkOutput("midrst wr", 134'(bus.o_data_wr), '0);
        checkOutput("midrst pulses", 134'({drop_p, over_p}), '0);
        s2 = words.size();
      end
      data = 8'(i);
      wr   = 1'b1;
      rst  = (i == 20);
    end
    @(posedge clk);
    #1;
    wr = 1'b0;
    idle(4);
    checkOutput("midrst no write", 134'(words.size() - s2), '0);
    s = words.size();
    applyStimulus(40, 8'h70, 7'd0, 1);
    idle(4);
    checkOutput("post rst count", 134'(words.size() - s), 134'(3));
    checkFrame("post rst", 40, 8'h70, s);

`ifdef IWT_RX_TIMESTAMP_EN
    checkOutput("ts at head", 134'(head_ts), 134'(48'h1234));
    checkOutput("ts held", 134'(ts), 134'(48'h1234));
`else
    checkOutput("ts off", 134'(ts), '0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/input_width_transform.md
Name: input_width_transform

Overview:
Receive-side counterpart of the 134-bit-to-GMII transmit path. Packs a byte stream (8-bit GMII receive data, already in the core clock domain) into 134-bit packet words with a 2-bit position header and a 4-bit invalid-byte count. Words are written to the downstream 134-bit receive FIFO. The block drops whole frames when that FIFO lacks room, truncates oversize frames, and optionally stamps frame arrival time.

Parameters:
MAX_BYTES, 1536, maximum accepted frame length in bytes; bytes beyond this are discarded.
DROP_THRESH, 32, a frame is dropped at its first byte if iv_fifo_usedw > DROP_THRESH.

Ports:
i_clk  in  1  core clock.
i_rst  in  1  reset, synchronous, active-high.
iv_data  in  8  receive byte.
i_data_wr  in  1  byte valid; held high for the whole frame; low for at least 1 cycle between frames.
iv_fifo_usedw  in  7  downstream FIFO fill level, in words.
iv_syned_global_time  in  48  synchronized global time.
ov_data  out  134  packet word: [133:132] position, [131:128] invalid bytes, [127:0] data with the first byte at [127:120].
o_data_wr  out  1  ov_data valid, one cycle per word.
ov_rx_timestamp  out  48  arrival time of the current frame.
o_pkt_drop_pulse  out  1  1-cycle pulse per frame dropped for lack of FIFO space.
o_oversize_pulse  out  1  1-cycle pulse per truncated frame.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset: all outputs = 0; state = IDLE; byte and lane counters = 0. Reset mid-frame abandons the partial word with no write. Bytes arriving while reset is high are ignored. A frame already in progress when reset releases is treated as DISC until i_data_wr = 0.
- Position code: 01 = head, 00 = middle, 10 = tail, 11 = head+tail (single-word frame).
- Invalid-byte count [131:128] = 16 − bytes in the word on the last word; 0 on all other words. Unused lanes are 0.
- IDLE:
  - On i_data_wr = 1 with iv_fifo_usedw > DROP_THRESH: pulse o_pkt_drop_pulse the next cycle, go to DISC.
  - Otherwise: write the byte to lane 0, set byte_cnt = 1, set the head flag, go to RECV.
- RECV, i_data_wr = 1:
  - If byte_cnt == MAX_BYTES: emit the held word as tail (10, or 11 if head is still pending), pulse o_oversize_pulse, go to DISC.
  - Else if the held word is full (16 lanes): emit it (01 if head, else 00), clear the head flag, start a new word with the byte in lane 0, increment byte_cnt.
  - Else: write the byte to lane (byte_cnt mod 16), increment byte_cnt.
- RECV, i_data_wr = 0: emit the held word as tail (10, or 11 if head is still pending) with the computed invalid count, go to IDLE.
- A full word is never emitted until the next byte or end-of-frame is seen, so a frame that is a multiple of 16 bytes ends with invalid count 0.
- Latency: o_data_wr and ov_data are registered, asserted the cycle after the triggering event (17th byte seen, or first cycle with i_data_wr = 0). Tail-to-IDLE takes one cycle; a new frame may start on the cycle immediately after the i_data_wr = 0 cycle.
- DISC: ignore input; go to IDLE on i_data_wr = 0. No writes occur.
- Byte counter is 11 bits and saturates at MAX_BYTES; it never wraps.
- Back-to-back frames with a 1-cycle gap must both be processed correctly.
- The FIFO space check is made only at the first byte; a frame in progress is never aborted for space.
- Pulses never overlap for the same frame.

Optional Feature:
Macro: IWT_RX_TIMESTAMP_EN.
- Defined: iv_syned_global_time is sampled on the cycle the first byte of an accepted frame is seen. ov_rx_timestamp holds that value from the head word's o_data_wr until the next accepted frame's head word.
- Not defined: ov_rx_timestamp is constant 0 and no timestamp register is built.

Test Plan:
- 65-byte frame, bytes 0x00..0x40, usedw = 0 -> 5 writes: headers 01/00/00/00/10. Tail invalid count = 15, tail [127:120] = 0x40, rest of tail = 0. First word [127:120] = 0x00.
- 1-byte frame 0xAA -> single write: header 11, invalid 15, [127:120] = 0xAA.
- 16-byte frame -> single write: header 11, invalid 0. 32-byte frame -> 2 writes: 01 then 10, invalid 0 on both.
- iv_fifo_usedw = 33 at the first byte of a 64-byte frame -> zero writes, one o_pkt_drop_pulse. The next frame with usedw = 32 is fully written (4 words).
- 1600-byte frame -> 96 writes, last header 10 with invalid 0, one o_oversize_pulse. A following 64-byte frame after a 1-cycle gap yields 4 correct writes.
- Reset asserted after byte 20 of a frame -> all outputs 0 the next cycle, no tail written, no write from the remainder. The next full frame is correct. With IWT_RX_TIMESTAMP_EN and time = 0x1234 at the first byte -> ov_rx_timestamp = 0x1234 at the head write.
